// File: rtl/legv8_pkg.sv
// Shared LEGv8 pipeline definitions: forwarding mux codes, XZR index and the
// shadow-pipeline stage entry used by the hazard/forwarding control.
package legv8_pkg;

   localparam int unsigned RegW = 5;

   localparam logic [1:0] FWD_REG = 2'd0;
   localparam logic [1:0] FWD_WB  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;

   localparam logic [RegW-1:0] XZR = 5'd31;

   typedef struct packed {
      logic            valid;
      logic            reg_write;
      logic            mem_read;
      logic [RegW-1:0] rd;
   } stage_t;

   // X31 reads as zero, so a write to it never produces a forwardable value.
   function automatic logic produces(stage_t e, logic [RegW-1:0] src);
      return e.valid & e.reg_write & (e.rd == src) & (src != XZR);
   endfunction

endpackage

// File: rtl/fwd_sel_gen.sv
// Priority comparator choosing the operand mux select for one source register;
// the youngest in-flight producer wins.
module fwd_sel_gen
   import legv8_pkg::*;
(
   input  logic [RegW-1:0] src_i,
   input  logic            use_src_i,
   input  stage_t          ex_i,
   input  stage_t          mem_i,
   output logic [1:0]      sel_o
);

   always_comb begin
      sel_o = FWD_REG;
      if (use_src_i) begin
         // EX producer moves to MEM next cycle, so its ALU result sits in EX/MEM.
         if (produces(ex_i, src_i)) begin
            sel_o = FWD_MEM;
         end else if (produces(mem_i, src_i)) begin
            sel_o = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand forwarding selects and load-use stall detection, driven by a
// shadow pipeline of destination metadata for the EX and MEM instructions.
module fwd_hazard_ctrl
   import legv8_pkg::*;
#(
   parameter int unsigned REG_W = 5,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rn,
   input  logic [REG_W-1:0] id_rm,
   input  logic             id_use_rn,
   input  logic             id_use_rm,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             stall,
   output logic [CNT_W-1:0] stall_count
);

   // The WB entry is never consulted: the register file is write-first, so
   // shifting MEM onward simply drops it.
   stage_t           ex_q, ex_d, mem_q, mem_d;
   logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic [1:0]       sel_a, sel_b;
   logic             advance;

   fwd_sel_gen u_sel_rn (
      .src_i     (id_rn),
      .use_src_i (id_use_rn),
      .ex_i      (ex_q),
      .mem_i     (mem_q),
      .sel_o     (sel_a)
   );

   fwd_sel_gen u_sel_rm (
      .src_i     (id_rm),
      .use_src_i (id_use_rm),
      .ex_i      (ex_q),
      .mem_i     (mem_q),
      .sel_o     (sel_b)
   );

   always_comb begin
      stall = id_valid & ~flush & ex_q.valid & ex_q.mem_read & ex_q.reg_write
            & (ex_q.rd != XZR)
            & ((id_use_rn & (ex_q.rd == id_rn)) | (id_use_rm & (ex_q.rd == id_rm)));
      advance = id_valid & ~stall & ~flush;

      ex_d = '0;
      if (advance) begin
         ex_d = '{valid: 1'b1, reg_write: id_reg_write, mem_read: id_mem_read, rd: id_rd};
      end
      mem_d = ex_q;

      fwd_a_d = advance ? sel_a : FWD_REG;
      fwd_b_d = advance ? sel_b : FWD_REG;

      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
         stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q          <= '0;
         mem_q         <= '0;
         fwd_a_q       <= FWD_REG;
         fwd_b_q       <= FWD_REG;
         stall_count_q <= '0;
      end else begin
         ex_q          <= ex_d;
         mem_q         <= mem_d;
         fwd_a_q       <= fwd_a_d;
         fwd_b_q       <= fwd_b_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign fwd_a       = fwd_a_q;
   assign fwd_b       = fwd_b_q;
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scenario bench for fwd_hazard_ctrl: expected selects are queued as each ID
// instruction is driven and checked once it occupies EX.
module tb_fwd_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid, id_use_rn, id_use_rm, id_reg_write, id_mem_read, flush;
   logic [4:0] id_rn, id_rm, id_rd;
   logic [1:0] fwd_a, fwd_b;
   logic       stall;
   logic [1:0] stall_count;

   int n_tests = 0;
   int n_fail  = 0;
   logic [3:0] sb[$];

   always #5 clk = ~clk;

   // Narrow counter so saturation is reachable in a short run.
   fwd_hazard_ctrl #(.REG_W(5), .CNT_W(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .id_rn        (id_rn),
      .id_rm        (id_rm),
      .id_use_rn    (id_use_rn),
      .id_use_rm    (id_use_rm),
      .id_rd        (id_rd),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .flush        (flush),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b),
      .stall        (stall),
      .stall_count  (stall_count)
   );

   task automatic drive_idle();
      id_valid = 0; id_rn = 0; id_rm = 0; id_use_rn = 0; id_use_rm = 0;
      id_rd = 0; id_reg_write = 0; id_mem_read = 0; flush = 0;
   endtask

   // One ID cycle: drive, check stall, queue the EX-cycle selects, check after the edge.
   task automatic step(input string name, input logic v, input logic [4:0] rn,
                       input logic [4:0] rm, input logic urn, input logic urm,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic fl, input logic exp_stall,
                       input logic [1:0] ea, input logic [1:0] eb);
      logic [3:0] exp;
      @(negedge clk);
      id_valid = v; id_rn = rn; id_rm = rm; id_use_rn = urn; id_use_rm = urm;
      id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
      #1;
      n_tests++;
      if (stall !== exp_stall) begin
         n_fail++;
         $display("FAIL %s stall: got %b want %b", name, stall, exp_stall);
      end
      sb.push_back({ea, eb});
      @(posedge clk);
      #1;
      n_tests++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL %s scoreboard: got empty queue want one entry", name);
      end else begin
         exp = sb.pop_front();
         if ({fwd_a, fwd_b} !== exp) begin
            n_fail++;
            $display("FAIL %s fwd: got a=%0d b=%0d want a=%0d b=%0d",
                     name, fwd_a, fwd_b, exp[3:2], exp[1:0]);
         end
      end
   endtask

   task automatic nop(input string name);
      step(name, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
   endtask

   task automatic drain();
      nop("drain0");
      nop("drain1");
   endtask

   task automatic test_reset();
      rst_n = 0;
      drive_idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      #1;
      n_tests++;
      if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin
         n_fail++;
         $display("FAIL reset fwd: got a=%0d b=%0d want a=0 b=0", fwd_a, fwd_b);
      end
      n_tests++;
      if (stall !== 1'b0) begin
         n_fail++;
         $display("FAIL reset stall: got %b want 0", stall);
      end
      n_tests++;
      if (stall_count !== 2'd0) begin
         n_fail++;
         $display("FAIL reset stall_count: got %0d want 0", stall_count);
      end
   endtask

   task automatic test_back_to_back();
      drain();
      step("b2b_add", 1, 5'd2, 5'd3, 1, 1, 5'd1, 1, 0, 0, 0, 2'd0, 2'd0);
      step("b2b_sub", 1, 5'd1, 5'd5, 1, 1, 5'd4, 1, 0, 0, 0, 2'd2, 2'd0);
      nop("b2b_tail");
   endtask

   task automatic test_distance2();
      drain();
      step("d2_add",   1, 5'd2, 5'd3, 1, 1, 5'd1, 1, 0, 0, 0, 2'd0, 2'd0);
      step("d2_other", 1, 5'd8, 5'd9, 1, 1, 5'd7, 1, 0, 0, 0, 2'd0, 2'd0);
      step("d2_and",   1, 5'd6, 5'd1, 1, 1, 5'd10, 1, 0, 0, 0, 2'd0, 2'd1);
      // Matching register but use bit clear must not forward.
      step("d2_nouse", 1, 5'd1, 5'd10, 0, 1, 5'd12, 1, 0, 0, 0, 2'd0, 2'd2);
   endtask

   task automatic test_youngest();
      drain();
      step("yw_add", 1, 5'd2, 5'd3, 1, 1, 5'd1, 1, 0, 0, 0, 2'd0, 2'd0);
      step("yw_orr", 1, 5'd2, 5'd3, 1, 1, 5'd1, 1, 0, 0, 0, 2'd0, 2'd0);
      step("yw_eor", 1, 5'd1, 5'd6, 1, 1, 5'd5, 1, 0, 0, 0, 2'd2, 2'd0);
   endtask

   task automatic test_load_use();
      drain();
      step("lu_ldur",   1, 5'd2, 5'd0, 1, 0, 5'd9, 1, 1, 0, 0, 2'd0, 2'd0);
      step("lu_hazard", 1, 5'd9, 5'd12, 1, 1, 5'd11, 1, 0, 0, 1, 2'd0, 2'd0);
      step("lu_replay", 1, 5'd9, 5'd12, 1, 1, 5'd11, 1, 0, 0, 0, 2'd1, 2'd0);
      n_tests++;
      if (stall_count !== 2'd1) begin
         n_fail++;
         $display("FAIL load_use stall_count: got %0d want 1", stall_count);
      end
   endtask

   task automatic test_xzr();
      drain();
      step("xzr_add",  1, 5'd2, 5'd3, 1, 1, 5'd31, 1, 0, 0, 0, 2'd0, 2'd0);
      step("xzr_sub",  1, 5'd31, 5'd31, 1, 1, 5'd4, 1, 0, 0, 0, 2'd0, 2'd0);
      step("xzr_ldur", 1, 5'd2, 5'd0, 1, 0, 5'd31, 1, 1, 0, 0, 2'd0, 2'd0);
      step("xzr_use",  1, 5'd31, 5'd31, 1, 1, 5'd5, 1, 0, 0, 0, 2'd0, 2'd0);
   endtask

   task automatic test_flush();
      drain();
      step("fl_ldur", 1, 5'd2, 5'd0, 1, 0, 5'd9, 1, 1, 0, 0, 2'd0, 2'd0);
      step("fl_kill", 1, 5'd9, 5'd12, 1, 1, 5'd11, 1, 0, 1, 0, 2'd0, 2'd0);
      // The killed ADD must not have entered EX as a producer of X11.
      step("fl_after", 1, 5'd11, 5'd0, 1, 0, 5'd13, 1, 0, 0, 0, 2'd0, 2'd0);
      n_tests++;
      if (stall_count !== 2'd1) begin
         n_fail++;
         $display("FAIL flush stall_count: got %0d want 1", stall_count);
      end
   endtask

   task automatic test_reset_mid();
      drain();
      step("rm_add", 1, 5'd2, 5'd3, 1, 1, 5'd1, 1, 0, 0, 0, 2'd0, 2'd0);
      step("rm_sub", 1, 5'd1, 5'd1, 1, 1, 5'd4, 1, 0, 0, 0, 2'd2, 2'd2);
      #2;
      rst_n = 0;
      #1;
      n_tests++;
      if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_mid fwd: got a=%0d b=%0d want a=0 b=0", fwd_a, fwd_b);
      end
      n_tests++;
      if (stall_count !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_mid stall_count: got %0d want 0", stall_count);
      end
      drive_idle();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      step("rm_first", 1, 5'd1, 5'd4, 1, 1, 5'd6, 1, 0, 0, 0, 2'd0, 2'd0);
   endtask

   task automatic test_saturate();
      logic [1:0] expc;
      for (int i = 0; i < 4; i++) begin
         drain();
         step("sat_ldur",   1, 5'd2, 5'd0, 1, 0, 5'd9, 1, 1, 0, 0, 2'd0, 2'd0);
         step("sat_hazard", 1, 5'd3, 5'd9, 1, 1, 5'd11, 1, 0, 0, 1, 2'd0, 2'd0);
         step("sat_replay", 1, 5'd3, 5'd9, 1, 1, 5'd11, 1, 0, 0, 0, 2'd0, 2'd1);
         expc = (i < 3) ? 2'(i + 1) : 2'd3;
         n_tests++;
         if (stall_count !== expc) begin
            n_fail++;
            $display("FAIL saturate stall_count[%0d]: got %0d want %0d", i, stall_count, expc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_distance2();
      test_youngest();
      test_load_use();
      test_xzr();
      test_flush();
      test_reset_mid();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
